// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
// Shadow entries are sized for the widest supported register address.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int STAGE_E = 2;
    localparam int STAGE_M = 3;

    // Register addresses narrower than this are zero-extended on entry.
    localparam int MAX_AW = 8;

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic [MAX_AW-1:0] dest;
        logic [MAX_AW-1:0] rs;
        logic [MAX_AW-1:0] rt;
    } stage_entry_t;

    // True when the stage will write a nonzero register equal to src.
    function automatic logic writes_reg(stage_entry_t s, logic [MAX_AW-1:0] src);
        return s.valid && s.regwrite && (s.dest != '0) && (s.dest == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-stage fields in, stall/flush/forward controls and counters out.
// The datapath side is the master; the hazard controller is the slave.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);

    logic              ValidD;
    logic [REG_AW-1:0] RsD;
    logic [REG_AW-1:0] RtD;
    logic              UsesRsD;
    logic              UsesRtD;
    logic              RegWriteD;
    logic              MemToRegD;
    logic [REG_AW-1:0] WriteRegD;
    logic              BranchTaken;

    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              FlushM;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [CNT_W-1:0]  StallCount;
    logic [CNT_W-1:0]  FlushCount;

    modport master (
        output ValidD, RsD, RtD, UsesRsD, UsesRtD, RegWriteD, MemToRegD,
               WriteRegD, BranchTaken,
        input  StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );

    modport slave (
        input  ValidD, RsD, RtD, UsesRsD, UsesRtD, RegWriteD, MemToRegD,
               WriteRegD, BranchTaken,
        output StallF, StallD, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );

endinterface

// File: rtl/hazard_shadow_stage.sv
// One shadow pipeline entry; reset or flush turns it into a bubble.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  stage_entry_t d,
    output stage_entry_t q
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use interlock, E-stage forwarding and branch squash for the 5-stage
// pipeline, driven from a private shadow copy of the E/M/W stage state.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int BRANCH_STAGE = STAGE_M,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    stage_entry_t e_d;
    stage_entry_t e_q;
    stage_entry_t m_q;
    stage_entry_t w_q;

    logic [MAX_AW-1:0] rs_d;
    logic [MAX_AW-1:0] rt_d;
    logic [MAX_AW-1:0] wreg_d;

    logic              lu;
    logic              bt;
    logic              flush_e;
    logic              flush_m;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              unused_w;

    function automatic logic [MAX_AW-1:0] widen(logic [REG_AW-1:0] r);
        return MAX_AW'(r);
    endfunction

    // A load in M is never forwarded: the interlock keeps its consumer
    // out of E until the loaded value is in W.
    function automatic logic [1:0] fwd_select(logic [MAX_AW-1:0] src);
        if (writes_reg(m_q, src) && !m_q.memtoreg) begin
            return FWD_MEM;
        end else if (writes_reg(w_q, src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign rs_d   = widen(hz.RsD);
    assign rt_d   = widen(hz.RtD);
    assign wreg_d = widen(hz.WriteRegD);
    assign bt     = hz.BranchTaken;

    assign lu = e_q.valid && e_q.memtoreg && e_q.regwrite && (e_q.dest != '0)
             && hz.ValidD
             && ((hz.UsesRsD && (rs_d == e_q.dest)) ||
                 (hz.UsesRtD && (rt_d == e_q.dest)));

    assign fwd_a = fwd_select(e_q.rs);
    assign fwd_b = fwd_select(e_q.rt);

    always_comb begin
        hz.StallF     = 1'b0;
        hz.StallD     = 1'b0;
        hz.FlushD     = 1'b0;
        flush_e       = 1'b0;
        flush_m       = 1'b0;
        hz.ForwardAE  = FWD_RF;
        hz.ForwardBE  = FWD_RF;
        hz.StallCount = '0;
        hz.FlushCount = '0;
        if (!reset) begin
            // A taken branch wins over the interlock so the PC takes the target.
            if (bt) begin
                hz.FlushD = 1'b1;
                flush_e   = 1'b1;
                flush_m   = (BRANCH_STAGE == STAGE_M);
            end else if (lu) begin
                hz.StallF = 1'b1;
                hz.StallD = 1'b1;
                flush_e   = 1'b1;
            end
            hz.ForwardAE  = fwd_a;
            hz.ForwardBE  = fwd_b;
            hz.StallCount = stall_cnt;
            hz.FlushCount = flush_cnt;
        end
    end

    assign hz.FlushE = flush_e;
    assign hz.FlushM = flush_m;

    always_comb begin
        e_d          = '0;
        e_d.valid    = hz.ValidD;
        e_d.regwrite = hz.RegWriteD;
        e_d.memtoreg = hz.MemToRegD;
        e_d.dest     = wreg_d;
        e_d.rs       = rs_d;
        e_d.rt       = rt_d;
    end

    hazard_shadow_stage u_stage_e (
        .clk   (clk),
        .reset (reset),
        .flush (flush_e),
        .d     (e_d),
        .q     (e_q)
    );

    hazard_shadow_stage u_stage_m (
        .clk   (clk),
        .reset (reset),
        .flush (flush_m),
        .d     (e_q),
        .q     (m_q)
    );

    hazard_shadow_stage u_stage_w (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d     (m_q),
        .q     (w_q)
    );

    // W only needs dest/regwrite/valid; its source fields are carried along.
    assign unused_w = ^{w_q.rs, w_q.rt, w_q.memtoreg};

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu && !bt && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
